// File: rtl/fetch_unit.sv
// RV32I instruction fetch front end: credit-limited imem requests, {pc, inst} buffer, redirect with stale-response drop.
// Optional macro FETCH_BYPASS_EN: present a fresh response combinationally when the buffer is empty.
package fetch_unit_pkg;
  typedef enum logic {
    PC_4   = 1'b0,
    PC_ALU = 1'b1
  } pc_sel_e;
endpackage

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic        o_inst_vld,
  input  logic        i_inst_rdy,
  input  logic        i_pc_sel,
  input  logic [31:0] i_alu_data
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = CW + 1;

  logic [31:0]   fpc_q, fpc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] out_n_q, out_n_d;
  logic [CW-1:0] drop_n_q, drop_n_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic          req_q, req_d;
  logic [31:0]   pc_mem_q   [DEPTH];
  logic [31:0]   inst_mem_q [DEPTH];

  logic grant, rsp_fire, rsp_ok, head_vld, byp;
  logic accept, redirect, push, pop;

  // Handshake qualifiers; a response with nothing outstanding is ignored.
  always_comb begin
    grant    = req_q & i_imem_gnt;
    rsp_fire = i_imem_rvalid & (out_n_q != '0);
    rsp_ok   = rsp_fire & (drop_n_q == '0);
    head_vld = (cnt_q != '0);
`ifdef FETCH_BYPASS_EN
    byp      = rsp_ok & ~head_vld;
`else
    byp      = 1'b0;
`endif
  end

  always_comb begin
`ifdef FETCH_BYPASS_EN
    o_inst_vld = head_vld | byp;
    o_inst     = byp ? i_imem_rdata : inst_mem_q[rd_ptr_q];
    o_pc       = byp ? rsp_pc_q     : pc_mem_q[rd_ptr_q];
`else
    o_inst_vld = head_vld;
    o_inst     = inst_mem_q[rd_ptr_q];
    o_pc       = pc_mem_q[rd_ptr_q];
`endif
    o_imem_req  = req_q;
    o_imem_addr = fpc_q;
  end

  // A bypassed word that is accepted never enters the buffer; a redirect kills any same-cycle response.
  always_comb begin
    accept   = o_inst_vld & i_inst_rdy;
    redirect = accept & (pc_sel_e'(i_pc_sel) == PC_ALU);
    push     = rsp_ok & ~redirect & ~(byp & accept);
    pop      = accept & ~byp;
  end

  always_comb begin
    fpc_d    = fpc_q;
    rsp_pc_d = rsp_pc_q;
    out_n_d  = out_n_q + CW'(grant) - CW'(rsp_fire);
    drop_n_d = drop_n_q;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);

    if (grant) begin
      fpc_d = fpc_q + 32'd4;
    end
    if (rsp_ok) begin
      rsp_pc_d = rsp_pc_q + 32'd4;
    end
    if (rsp_fire && (drop_n_q != '0)) begin
      drop_n_d = drop_n_q - CW'(1);
    end
    // Everything still in flight after this cycle belongs to the abandoned path.
    if (redirect) begin
      fpc_d    = i_alu_data & ~32'd3;
      rsp_pc_d = i_alu_data & ~32'd3;
      drop_n_d = out_n_d;
      cnt_d    = '0;
      rd_ptr_d = wr_ptr_q;
    end
    req_d = (SW'(out_n_d) + SW'(cnt_d)) < SW'(DEPTH);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fpc_q    <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      cnt_q    <= '0;
      out_n_q  <= '0;
      drop_n_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      req_q    <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
    end else begin
      fpc_q    <= fpc_d;
      rsp_pc_q <= rsp_pc_d;
      cnt_q    <= cnt_d;
      out_n_q  <= out_n_d;
      drop_n_q <= drop_n_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      req_q    <= req_d;
      if (push) begin
        pc_mem_q[wr_ptr_q]   <= rsp_pc_q;
        inst_mem_q[wr_ptr_q] <= i_imem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: randomized in-order imem model and a program-order reference for the accepted stream.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned DEPTH    = 2;
`ifdef FETCH_BYPASS_EN
  localparam int EXP_LAT = 2;
`else
  localparam int EXP_LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        gnt, rvalid, rdy, pc_sel;
  logic [31:0] rdata, alu;
  logic [31:0] o_inst, o_pc;
  logic        o_inst_vld;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .o_imem_req   (o_imem_req),
    .o_imem_addr  (o_imem_addr),
    .i_imem_gnt   (gnt),
    .i_imem_rvalid(rvalid),
    .i_imem_rdata (rdata),
    .o_inst       (o_inst),
    .o_pc         (o_pc),
    .o_inst_vld   (o_inst_vld),
    .i_inst_rdy   (rdy),
    .i_pc_sel     (pc_sel),
    .i_alu_data   (alu)
  );

  int errs = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] rand_target();
    if ($urandom_range(0, 7) == 0) return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
    return 32'($urandom_range(0, 4095));
  endfunction

  // Memory model: in-order queue of granted addresses with earliest response cycle.
  int          cyc = 0;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  // Reference: PC of the next instruction in program order, and next address to be fetched.
  logic [31:0] exp_pc, exp_fetch;
  int          gnt_pct, rsp_pct, rdy_pct, redir_pct, max_extra;
  logic        redir_armed, redir_watch, seen_vld, prev_stall;
  logic [31:0] redir_at, redir_tgt, prev_pc, prev_inst;
  int          accepts = 0;

  task automatic clear_model();
    mq_addr.delete();
    mq_due.delete();
    exp_pc      = RESET_PC;
    exp_fetch   = RESET_PC;
    prev_stall  = 1'b0;
    redir_armed = 1'b0;
    redir_watch = 1'b0;
  endtask

  task automatic set_knobs(input int g, input int r, input int d, input int x, input int e);
    gnt_pct = g; rsp_pct = r; rdy_pct = d; redir_pct = x; max_extra = e;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"},  32'(o_imem_req), 32'd0);
    check({tag, "_addr"}, o_imem_addr, RESET_PC);
    check({tag, "_vld"},  32'(o_inst_vld), 32'd0);
    check({tag, "_inst"}, o_inst, 32'd0);
    check({tag, "_pc"},   o_pc, 32'd0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; gnt = 1'b0; rvalid = 1'b0; rdy = 1'b0; pc_sel = PC_4; alu = '0; rdata = '0;
    #1;
    check_reset_vals(tag);
    @(negedge clk);
    check_reset_vals({tag, "_held"});
    rst = 1'b0;
    clear_model();
  endtask

  // One clock cycle: drive inputs after the falling edge, sample, then account for this cycle's events.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    gnt = ($urandom_range(0, 99) < gnt_pct);
    if (mq_addr.size() > 0 && mq_due[0] <= cyc && $urandom_range(0, 99) < rsp_pct) begin
      rvalid = 1'b1;
      rdata  = mem_word(mq_addr[0]);
    end else begin
      rvalid = 1'b0;
      rdata  = $urandom;
    end
    rdy = ($urandom_range(0, 99) < rdy_pct);
    #1;
    if (redir_armed && o_inst_vld && o_pc == redir_at) begin
      rdy = 1'b1; pc_sel = PC_ALU; alu = redir_tgt;
      redir_armed = 1'b0;
    end else begin
      pc_sel = ($urandom_range(0, 99) < redir_pct) ? PC_ALU : PC_4;
      alu    = rand_target();
    end
    seen_vld = o_inst_vld;
    if (prev_stall) begin
      check("hold_pc", o_pc, prev_pc);
      check("hold_inst", o_inst, prev_inst);
    end
    if (o_imem_req && gnt) begin
      check("fetch_addr", o_imem_addr, exp_fetch);
      mq_addr.push_back(o_imem_addr);
      mq_due.push_back(cyc + 1 + int'($urandom_range(0, max_extra)));
      exp_fetch += 32'd4;
    end
    if (rvalid) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    if (o_inst_vld && rdy) begin
      accepts++;
      if (redir_watch) begin
        check("redir_next_pc", o_pc, redir_tgt & ~32'd3);
        redir_watch = 1'b0;
      end
      check("acc_pc", o_pc, exp_pc);
      check("acc_inst", o_inst, mem_word(exp_pc));
      if (pc_sel == PC_ALU) begin
        if (alu == redir_tgt && !redir_armed && o_pc == redir_at) redir_watch = 1'b1;
        exp_pc    = alu & ~32'd3;
        exp_fetch = alu & ~32'd3;
      end else begin
        exp_pc += 32'd4;
      end
    end
    prev_stall = o_inst_vld && !rdy;
    prev_pc    = o_pc;
    prev_inst  = o_inst;
  endtask

  initial begin
    int lat, n_acc;
    rst = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdy = 1'b0; pc_sel = PC_4; alu = '0; rdata = '0;
    redir_at = '1; redir_tgt = '0;
    clear_model();
    #1;
    do_reset("rst0");

    // Start-up latency and in-order stream at full speed.
    set_knobs(100, 100, 100, 0, 0);
    lat = 0;
    seen_vld = 1'b0;
    while (!seen_vld && lat < 20) begin
      cycle();
      lat++;
    end
    check("first_vld_lat", 32'(lat), 32'(EXP_LAT));
    n_acc = accepts;
    repeat (6) cycle();
`ifdef FETCH_BYPASS_EN
    check("bypass_rate", 32'(accepts - n_acc), 32'd6);
`endif

    // Stall decode for 5 cycles: credit must close the request port.
    set_knobs(100, 100, 0, 0, 0);
    repeat (5) cycle();
    check("stall_req", 32'(o_imem_req), 32'd0);
    check("stall_inflight", 32'(mq_addr.size()), 32'd0);
    set_knobs(100, 100, 100, 0, 0);
    repeat (8) cycle();

    // Redirect at PC 0x8 to 0x103 with slow responses keeping requests in flight.
    do_reset("rst1");
    set_knobs(100, 100, 100, 0, 1);
    redir_at = 32'h8; redir_tgt = 32'h103; redir_armed = 1'b1;
    repeat (16) cycle();
    check("redir_taken", 32'(redir_armed), 32'd0);
    check("redir_seen", 32'(redir_watch), 32'd0);
    redir_at = '1;

    // Grant withheld: address and request hold.
    do_reset("rst2");
    set_knobs(0, 100, 100, 0, 0);
    repeat (4) begin
      cycle();
      check("nogrant_req", 32'(o_imem_req), 32'd1);
      check("nogrant_addr", o_imem_addr, RESET_PC);
    end
    set_knobs(100, 100, 0, 0, 0);
    repeat (4) cycle();

    // Asynchronous reset with a full buffer, then restart from RESET_PC.
    #2;
    rst = 1'b1; rvalid = 1'b0;
    #1;
    check_reset_vals("async");
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    set_knobs(100, 100, 100, 0, 0);
    n_acc = accepts;
    lat = 0;
    while (accepts == n_acc && lat < 20) begin
      cycle();
      lat++;
    end
    check("restart_acc", 32'(accepts - n_acc), 32'd1);

    // Randomized traffic with varying grant, latency, ready and redirect rates.
    for (int blk = 0; blk < 15; blk++) begin
      set_knobs($urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(20, 100),
                $urandom_range(0, 30), $urandom_range(0, 3));
      repeat (200) cycle();
    end
    check("progress", 32'(accepts > 300), 32'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
